universal_register: RTL and testbench
=====================================

// Module: universal_register
//
// PURPOSE
//   Parametrised successor to the 4-bit load-only register. Holds a WIDTH-bit
//   value and, per clock, can hold, load, increment, decrement, shift or rotate
//   it, with a registered carry/shift-out bit and a zero flag.
//   Serves as the general-purpose datapath register for the CPU:
//   - program counter (INC, LOAD)
//   - loop counters (DEC, zero flag)
//   - serial/shift work (SHL/SHR/ROL/ROR)
//
// PARAMETERS
//   WIDTH      4   register width in bits (>= 2)
//   RESET_VAL  0   value loaded into result on reset (WIDTH bits)
//
// PORTS
//   clk      in   1      clock; all updates on rising edge
//   reset_n  in   1      asynchronous reset, active low
//   en_n     in   1      operation enable, active low; 1 = hold regardless of mode
//   mode     in   3      operation select (codes below)
//   data     in   WIDTH  parallel load data
//   sin      in   1      serial input for SHL/SHR
//   result   out  WIDTH  register contents
//   cout     out  1      registered carry / borrow / shifted-out bit
//   zero     out  1      1 when result == 0 (decoded from registered result)
//
// BEHAVIOUR
//   Reset (reset_n = 0, asynchronous, takes effect immediately, mid-operation
//   included):
//   - result = RESET_VAL, cout = 0; zero follows result.
//   Priority: reset > en_n = 1 (hold everything) > mode.
//   Latency: one clock; new result/cout are visible after the rising edge that
//   samples en_n = 0.
//
//   Mode codes, with next result / next cout:
//     0 HOLD  result unchanged / cout unchanged
//     1 LOAD  data / 0
//     2 INC   result + 1 mod 2^WIDTH / 1 iff result was all-ones (wrap to 0)
//     3 DEC   result - 1 mod 2^WIDTH / 1 iff result was 0 (wrap to all-ones, borrow)
//     4 SHL   {result[WIDTH-2:0], sin} / result[WIDTH-1]
//     5 SHR   {sin, result[WIDTH-1:1]} / result[0]
//     6 ROL   {result[WIDTH-2:0], result[WIDTH-1]} / result[WIDTH-1]
//     7 ROR   {result[0], result[WIDTH-1:1]} / result[0]
//
//   Rules:
//   - Arithmetic is WIDTH+1 bits internally: the MSB becomes cout, the low
//     WIDTH bits become result. No saturation.
//   - en_n = 1 freezes result and cout even if mode or data change.
//   - zero is combinational from result only; no extra latency and no glitch
//     from inputs.
//   - Reset release is synchronous to nothing: the first op executes on the
//     first rising edge after reset_n rises.
//
// STRUCTURE
//   Shared package (cpu_defs): localparams MODE_HOLD..MODE_ROR (3-bit codes
//   above), reused by the control decoder.
//   Optional sub-module ureg_next: purely combinational
//   (mode, result, data, sin) -> (next_result, next_cout).
//   Top level holds the single always block with the async reset and the en_n
//   gate. No other state.
//
// TESTING (WIDTH = 4, RESET_VAL = 0 unless noted)
//   1. reset_n low mid-cycle while result = 4'hA
//      -> result = 0, cout = 0, zero = 1 immediately, before any clk edge.
//   2. LOAD 4'hE, then INC, INC, INC
//      -> result E, F, 0 (cout = 1, zero = 1), then 1 (cout = 0).
//   3. LOAD 0, then DEC
//      -> result = F, cout = 1; DEC again -> result = E, cout = 0.
//   4. LOAD 4'b1001, then SHL sin = 0 -> 0010, cout = 1;
//      then SHR sin = 1 -> 1001, cout = 0.
//   5. LOAD 4'b1000, then ROL -> 0001, cout = 1;
//      ROR twice -> 1000 (cout = 1), then 0100 (cout = 0).
//   6. en_n = 1 with mode = INC and data toggling for 5 clocks
//      -> result and cout unchanged. Repeat with RESET_VAL = 4'h5:
//      reset -> result = 5, zero = 0.

Source files
------------

// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal datapath register: operation codes
// used by the register and by the CPU control decoder.
package universal_register_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_INC  = 3'd2,
    MODE_DEC  = 3'd3,
    MODE_SHL  = 3'd4,
    MODE_SHR  = 3'd5,
    MODE_ROL  = 3'd6,
    MODE_ROR  = 3'd7
  } mode_e;

endpackage

// File: rtl/universal_register_if.sv
// Operation/result bundle between the CPU control path (master) and a
// universal_register instance (slave).
interface universal_register_if #(
  parameter int WIDTH = 4
);
  import universal_register_pkg::*;

  logic             en_n;
  mode_e            mode;
  logic [WIDTH-1:0] data;
  logic             sin;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output en_n, mode, data, sin,
    input  result, cout, zero
  );

  modport slave (
    input  en_n, mode, data, sin,
    output result, cout, zero
  );

endinterface

// File: rtl/universal_register_next.sv
// Combinational next-state function of the universal register: computes the
// next result and carry/shift-out bit for the selected operation.
module universal_register_next
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] data,
  input  logic             sin,
  input  logic             cout,
  output logic [WIDTH-1:0] next_result,
  output logic             next_cout
);

  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;

  // Arithmetic is one bit wider so the top bit carries out / borrows out
  assign inc_s = {1'b0, result} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s = {1'b0, result} - {{WIDTH{1'b0}}, 1'b1};

  // Operation select
  always_comb begin
    next_result = result;
    next_cout   = cout;
    case (mode)
      MODE_HOLD: begin
        next_result = result;
        next_cout   = cout;
      end
      MODE_LOAD: begin
        next_result = data;
        next_cout   = 1'b0;
      end
      MODE_INC: begin
        next_result = inc_s[WIDTH-1:0];
        next_cout   = inc_s[WIDTH];
      end
      MODE_DEC: begin
        next_result = dec_s[WIDTH-1:0];
        next_cout   = dec_s[WIDTH];
      end
      MODE_SHL: begin
        next_result = {result[WIDTH-2:0], sin};
        next_cout   = result[WIDTH-1];
      end
      MODE_SHR: begin
        next_result = {sin, result[WIDTH-1:1]};
        next_cout   = result[0];
      end
      MODE_ROL: begin
        next_result = {result[WIDTH-2:0], result[WIDTH-1]};
        next_cout   = result[WIDTH-1];
      end
      MODE_ROR: begin
        next_result = {result[0], result[WIDTH-1:1]};
        next_cout   = result[0];
      end
      default: begin
        next_result = result;
        next_cout   = cout;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// General-purpose WIDTH-bit datapath register: hold/load/inc/dec/shift/rotate
// with a registered carry/shift-out bit and a zero flag decoded from the state.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  universal_register_if.slave  bus
);

  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic [WIDTH-1:0] next_result_s;
  logic             next_cout_s;

  universal_register_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode        (bus.mode),
    .result      (result_r),
    .data        (bus.data),
    .sin         (bus.sin),
    .cout        (cout_r),
    .next_result (next_result_s),
    .next_cout   (next_cout_s)
  );

  // State register: async reset, then en_n gates every update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_r <= RESET_VAL;
      cout_r   <= 1'b0;
    end else if (!bus.en_n) begin
      result_r <= next_result_s;
      cout_r   <= next_cout_s;
    end else begin
      result_r <= result_r;
      cout_r   <= cout_r;
    end
  end

  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  // Decoded from the register only, so input changes cannot glitch it
  assign bus.zero   = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register: directed scenarios plus a
// random sequence, with expected values queued in a scoreboard.
module tb_universal_register;
  import universal_register_pkg::*;

  typedef struct {
    logic       en_n;
    mode_e      mode;
    logic [3:0] data;
    logic       sin;
    logic [3:0] r;
    logic       c;
  } op_t;

  typedef struct {
    logic [3:0] r;
    logic       c;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  universal_register_if #(.WIDTH(4)) bus  ();
  universal_register_if #(.WIDTH(4)) bus5 ();

  universal_register #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  universal_register #(.WIDTH(4), .RESET_VAL(4'h5)) dut5 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Apply one operation, wait for the sampling edge, return 1 time unit after it
  task automatic step(input logic en_n, input mode_e mode, input logic [3:0] data,
                      input logic sin);
    bus.en_n = en_n;
    bus.mode = mode;
    bus.data = data;
    bus.sin  = sin;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n   = 1'b0;
    bus5.en_n = 1'b1;
    bus5.mode = MODE_INC;
    bus5.data = 4'h0;
    bus5.sin  = 1'b0;
    step(1'b1, MODE_HOLD, 4'h0, 1'b0);
    step(1'b1, MODE_HOLD, 4'h0, 1'b0);
    n_checks++;
    if (bus.result !== 4'h0 || bus.cout !== 1'b0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: result=%h cout=%b zero=%b, required 0/0/1",
               bus.result, bus.cout, bus.zero);
    end
    n_checks++;
    if (bus5.result !== 4'h5 || bus5.cout !== 1'b0 || bus5.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_val5: result=%h cout=%b zero=%b, required 5/0/0",
               bus5.result, bus5.cout, bus5.zero);
    end
    #2 reset_n = 1'b1;
    sb.push_back('{4'hA, 1'b0});
    step(1'b0, MODE_LOAD, 4'hA, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus.result !== e.r || bus.cout !== e.c || bus.zero !== (e.r == 4'h0)) begin
      n_fail++;
      $display("FAIL first_load: result=%h cout=%b, required %h/%b", bus.result, bus.cout, e.r, e.c);
    end
    // Mid-cycle asynchronous reset with no clock edge in between
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== 4'h0 || bus.cout !== 1'b0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: result=%h cout=%b zero=%b, required 0/0/1",
               bus.result, bus.cout, bus.zero);
    end
    n_checks++;
    if (bus5.result !== 4'h5 || bus5.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset5: result=%h zero=%b, required 5/0", bus5.result, bus5.zero);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic run_ops(input string name, input op_t ops[$]);
    exp_t e;
    foreach (ops[i]) begin
      sb.push_back('{ops[i].r, ops[i].c});
      step(ops[i].en_n, ops[i].mode, ops[i].data, ops[i].sin);
      e = sb.pop_front();
      n_checks++;
      if (bus.result !== e.r || bus.cout !== e.c || bus.zero !== (e.r == 4'h0)) begin
        n_fail++;
        $display("FAIL %s[%0d]: result=%h cout=%b zero=%b, required %h/%b/%b",
                 name, i, bus.result, bus.cout, bus.zero, e.r, e.c, (e.r == 4'h0));
      end
    end
  endtask

  task automatic test_inc();
    op_t ops[$];
    ops.push_back('{1'b0, MODE_LOAD, 4'hE, 1'b0, 4'hE, 1'b0});
    ops.push_back('{1'b0, MODE_INC,  4'h0, 1'b0, 4'hF, 1'b0});
    ops.push_back('{1'b0, MODE_INC,  4'h0, 1'b0, 4'h0, 1'b1});
    ops.push_back('{1'b0, MODE_INC,  4'h0, 1'b0, 4'h1, 1'b0});
    run_ops("inc", ops);
  endtask

  task automatic test_dec();
    op_t ops[$];
    ops.push_back('{1'b0, MODE_LOAD, 4'h0, 1'b0, 4'h0, 1'b0});
    ops.push_back('{1'b0, MODE_DEC,  4'h7, 1'b0, 4'hF, 1'b1});
    ops.push_back('{1'b0, MODE_DEC,  4'h7, 1'b0, 4'hE, 1'b0});
    ops.push_back('{1'b0, MODE_HOLD, 4'h3, 1'b1, 4'hE, 1'b0});
    run_ops("dec", ops);
  endtask

  task automatic test_shift();
    op_t ops[$];
    ops.push_back('{1'b0, MODE_LOAD, 4'b1001, 1'b0, 4'b1001, 1'b0});
    ops.push_back('{1'b0, MODE_SHL,  4'h0,    1'b0, 4'b0010, 1'b1});
    ops.push_back('{1'b0, MODE_SHR,  4'h0,    1'b1, 4'b1001, 1'b0});
    ops.push_back('{1'b0, MODE_SHL,  4'h0,    1'b1, 4'b0011, 1'b1});
    ops.push_back('{1'b0, MODE_SHR,  4'h0,    1'b0, 4'b0001, 1'b1});
    run_ops("shift", ops);
  endtask

  task automatic test_rotate();
    op_t ops[$];
    ops.push_back('{1'b0, MODE_LOAD, 4'b1000, 1'b0, 4'b1000, 1'b0});
    ops.push_back('{1'b0, MODE_ROL,  4'h0,    1'b0, 4'b0001, 1'b1});
    ops.push_back('{1'b0, MODE_ROR,  4'h0,    1'b0, 4'b1000, 1'b1});
    ops.push_back('{1'b0, MODE_ROR,  4'h0,    1'b1, 4'b0100, 1'b0});
    run_ops("rotate", ops);
  endtask

  task automatic test_hold();
    op_t ops[$];
    ops.push_back('{1'b0, MODE_LOAD, 4'hF, 1'b0, 4'hF, 1'b0});
    ops.push_back('{1'b0, MODE_INC,  4'h0, 1'b0, 4'h0, 1'b1});
    for (int i = 0; i < 5; i++)
      ops.push_back('{1'b1, MODE_INC, (i % 2 == 0) ? 4'hA : 4'h5, 1'b1, 4'h0, 1'b1});
    ops.push_back('{1'b1, MODE_LOAD, 4'h6, 1'b0, 4'h0, 1'b1});
    run_ops("hold", ops);
  endtask

  task automatic test_random();
    op_t        ops[$];
    logic [3:0] m_r;
    logic       m_c;
    op_t        o;
    m_r = 4'h3;
    m_c = 1'b0;
    ops.push_back('{1'b0, MODE_LOAD, 4'h3, 1'b0, 4'h3, 1'b0});
    for (int i = 0; i < 40; i++) begin
      o.en_n = ($urandom_range(0, 3) == 0);
      o.mode = mode_e'($urandom_range(0, 7));
      o.data = 4'($urandom_range(0, 15));
      o.sin  = 1'($urandom_range(0, 1));
      if (!o.en_n) begin
        case (o.mode)
          MODE_LOAD: begin m_r = o.data; m_c = 1'b0; end
          MODE_INC:  begin m_c = (m_r == 4'hF); m_r = 4'((int'(m_r) + 1) % 16); end
          MODE_DEC:  begin m_c = (m_r == 4'h0); m_r = 4'((int'(m_r) + 15) % 16); end
          MODE_SHL:  begin m_c = m_r[3]; m_r = {m_r[2:0], o.sin}; end
          MODE_SHR:  begin m_c = m_r[0]; m_r = {o.sin, m_r[3:1]}; end
          MODE_ROL:  begin m_c = m_r[3]; m_r = {m_r[2:0], m_r[3]}; end
          MODE_ROR:  begin m_c = m_r[0]; m_r = {m_r[0], m_r[3:1]}; end
          default:   begin end
        endcase
      end
      o.r = m_r;
      o.c = m_c;
      ops.push_back(o);
    end
    run_ops("random", ops);
  endtask

  task automatic test_hold_val5();
    n_checks++;
    if (bus5.result !== 4'h5 || bus5.cout !== 1'b0 || bus5.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_val5: result=%h cout=%b zero=%b, required 5/0/0",
               bus5.result, bus5.cout, bus5.zero);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_inc();
    test_dec();
    test_shift();
    test_rotate();
    test_hold();
    test_random();
    test_hold_val5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
